vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised raster timing generator for the video path.
//  Produces pixel-rate strobe, pixel coordinates, hsync/vsync with selectable polarity, display-active flag and line/frame strobes.
//  Successor to the fixed 640x480 sync generator: any resolution, any integer clock-to-pixel ratio, run/hold control.
//  Sits between the system clock and the pixel/character renderers feeding the VGA DAC pins.
// PARAMETERS
//  HD      640  horizontal display pixels
//  HF      16   horizontal front porch (after display)
//  HR      96   horizontal sync (retrace) width
//  HB      48   horizontal back porch (after sync)
//  VD      480  vertical display lines
//  VF      10   vertical front porch
//  VR      2    vertical sync width
//  VB      33   vertical back porch
//  H_POL   0    active level of hsync (0 = active-low)
//  V_POL   0    active level of vsync
//  CLK_DIV 2    system clocks per pixel, >=1
//  CW      10   coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  clk       in   1   system clock
//  rst       in   1   asynchronous reset, active-high
//  en        in   1   1 = run, 0 = freeze raster
//  pix_tick  out  1   one-clk strobe, one per pixel period
//  px_X      out  CW  current column, 0..H_TOTAL-1
//  px_Y      out  CW  current line, 0..V_TOTAL-1
//  hsync     out  1   horizontal sync, H_POL active
//  vsync     out  1   vertical sync, V_POL active
//  video_on  out  1   1 when px_X<HD and px_Y<VD
//  eol       out  1   one-clk strobe: last pixel of a line
//  eof       out  1   one-clk strobe: last pixel of a frame
// BEHAVIOUR
//  H_TOTAL=HD+HF+HR+HB, V_TOTAL=VD+VF+VR+VB; line order: display, front porch, sync, back porch.
//  Reset values: div counter 0, px_X=0, px_Y=0, hsync=~H_POL, vsync=~V_POL, video_on=1, pix_tick=eol=eof=0.
//  Divider counts 0..CLK_DIV-1 while en=1, wraps to 0.
//  pix_tick = en & (div==CLK_DIV-1), combinational. With CLK_DIV=1 it equals en.
//  On a clock edge with pix_tick=1:
//    px_X increments, wrapping H_TOTAL-1 -> 0.
//    px_Y increments only when px_X wraps; px_Y wraps V_TOTAL-1 -> 0.
//  hsync, vsync and video_on are registers computed from the next coordinates.
//    They change on the same edge as px_X/px_Y, so there is zero skew versus coordinates.
//  hsync active iff HD+HF <= px_X <= HD+HF+HR-1.
//  vsync active iff VD+VF <= px_Y <= VD+VF+VR-1, for the whole of each such line.
//  eol = pix_tick & (px_X==H_TOTAL-1).
//  eof = eol & (px_Y==V_TOTAL-1).
//  en=0 behaviour:
//    div counter is cleared to 0; pix_tick, eol and eof are 0.
//    Coordinates, hsync, vsync and video_on hold their values.
//    After en returns to 1, the first pix_tick comes CLK_DIV-1 clocks later.
//  Reset asserted mid-frame: all state returns to its reset values immediately (async); raster restarts at (0,0).
//  No other sequencing state; every coordinate pair in the raster is reachable and the frame is exactly H_TOTAL*V_TOTAL ticks.
// TESTING
//  1 Defaults, en=1, release rst at t0 -> pix_tick at clocks 1,3,5...; px_X 799->0 after 1600 clocks; eol once per 1600 clocks.
//  2 Defaults -> hsync low exactly for px_X 656..751; vsync low for px_Y 490..491; video_on low when px_X>=640 or px_Y>=480.
//  3 Defaults -> eof once per 840000 clocks, coincident with px_X=799,px_Y=524; next tick gives (0,0).
//  4 HD=4,HF=1,HR=2,HB=1, VD=3,VF=1,VR=1,VB=1, CLK_DIV=1, H_POL=V_POL=1:
//      hsync high at px_X 5..6; vsync high on px_Y=4; frame length 48 clocks.
//  5 Defaults; drop en for 10 clocks at px_X=100 -> coordinates and syncs frozen, no pix_tick; next tick after en rises moves px_X to 101.
//  6 Defaults; pulse rst while at (700,491) -> same cycle px_X=px_Y=0, hsync=vsync=1, video_on=1; raster restarts cleanly.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: divides the system clock down to a pixel strobe,
// walks the (px_X, px_Y) raster and produces sync, blanking and line/frame
// strobes. Sync and video_on are registered from the next coordinates, so
// they change on the same edge as the coordinates themselves.
//
// Handshake: none. en is a level that runs (1) or freezes (0) the raster.
// pix_tick, eol and eof are single-clock strobes, valid only while en=1.
module vga_timing_gen #(
    parameter int HD      = 640,
    parameter int HF      = 16,
    parameter int HR      = 96,
    parameter int HB      = 48,
    parameter int VD      = 480,
    parameter int VF      = 10,
    parameter int VR      = 2,
    parameter int VB      = 33,
    parameter bit H_POL   = 1'b0,
    parameter bit V_POL   = 1'b0,
    parameter int CLK_DIV = 2,
    parameter int CW      = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          pix_tick,
    output logic [CW-1:0] px_X,
    output logic [CW-1:0] px_Y,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          eol,
    output logic          eof
);

    localparam int H_TOTAL = HD + HF + HR + HB;
    localparam int V_TOTAL = VD + VF + VR + VB;
    // A one-bit divider is kept even for CLK_DIV=1; it then simply stays 0.
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] X_DISP   = CW'(HD);
    localparam logic [CW-1:0] Y_DISP   = CW'(VD);
    localparam logic [CW-1:0] HS_FIRST = CW'(HD + HF);
    localparam logic [CW-1:0] HS_LAST  = CW'(HD + HF + HR - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(VD + VF);
    localparam logic [CW-1:0] VS_LAST  = CW'(VD + VF + VR - 1);

    logic [DW-1:0] div;
    logic          x_last;
    logic          y_last;
    logic [CW-1:0] x_next;
    logic [CW-1:0] y_next;
    logic          hs_zone;
    logic          vs_zone;
    logic          disp_zone;

    // Clock divider: counts enabled clocks, cleared whenever the raster is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (!en) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + DW'(1);
        end
    end

    // The strobe is suppressed while reset is held so reset outputs are quiet
    // even when CLK_DIV=1 makes the divider condition permanently true.
    assign pix_tick = en & ~rst & (div == DIV_LAST);

    assign x_last = (px_X == X_LAST);
    assign y_last = (px_Y == Y_LAST);
    assign eol    = pix_tick & x_last;
    assign eof    = eol & y_last;

    // Next raster position and the zone flags derived from it.
    always_comb begin
        x_next    = px_X;
        y_next    = px_Y;
        if (x_last) begin
            x_next = '0;
            y_next = y_last ? '0 : px_Y + CW'(1);
        end else begin
            x_next = px_X + CW'(1);
        end
        hs_zone   = (x_next >= HS_FIRST) && (x_next <= HS_LAST);
        vs_zone   = (y_next >= VS_FIRST) && (y_next <= VS_LAST);
        disp_zone = (x_next < X_DISP) && (y_next < Y_DISP);
    end

    // Coordinates and sync/blank registers advance together on each pixel strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_X     <= '0;
            px_Y     <= '0;
            hsync    <= ~H_POL;
            vsync    <= ~V_POL;
            video_on <= 1'b1;
        end else if (pix_tick) begin
            px_X     <= x_next;
            px_Y     <= y_next;
            hsync    <= hs_zone ? H_POL : ~H_POL;
            vsync    <= vs_zone ? V_POL : ~V_POL;
            video_on <= disp_zone;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing, a tiny raster
// with active-high syncs and CLK_DIV=1, and default horizontal timing with a
// short vertical frame) checked every cycle against a raster model driven by
// a linear pixel index, plus directed literal checks at known clock counts.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, en_a = 1'b1;
    logic rst_b = 1'b1, en_b = 1'b0;
    logic rst_c = 1'b1, en_c = 1'b1;

    logic       tick_a, hs_a, vs_a, von_a, eol_a, eof_a;
    logic [9:0] x_a, y_a;
    logic       tick_b, hs_b, vs_b, von_b, eol_b, eof_b;
    logic [9:0] x_b, y_b;
    logic       tick_c, hs_c, vs_c, von_c, eol_c, eof_c;
    logic [9:0] x_c, y_c;

    int  checks = 0;
    int  passed = 0;
    logic cmp_on = 1'b0;
    logic done_a = 1'b0, done_b = 1'b0, done_c = 1'b0;

    vga_timing_gen u_a (
        .clk(clk), .rst(rst_a), .en(en_a), .pix_tick(tick_a), .px_X(x_a), .px_Y(y_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(von_a), .eol(eol_a), .eof(eof_a)
    );

    vga_timing_gen #(
        .HD(4), .HF(1), .HR(2), .HB(1), .VD(3), .VF(1), .VR(1), .VB(1),
        .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(1), .CW(10)
    ) u_b (
        .clk(clk), .rst(rst_b), .en(en_b), .pix_tick(tick_b), .px_X(x_b), .px_Y(y_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(von_b), .eol(eol_b), .eof(eof_b)
    );

    vga_timing_gen #(
        .VD(8), .VF(2), .VR(2), .VB(3), .H_POL(1'b0), .V_POL(1'b1), .CLK_DIV(2)
    ) u_c (
        .clk(clk), .rst(rst_c), .en(en_c), .pix_tick(tick_c), .px_X(x_c), .px_Y(y_c),
        .hsync(hs_c), .vsync(vs_c), .video_on(von_c), .eol(eol_c), .eof(eof_c)
    );

    // ---------------- model ----------------
    // Expected outputs from a linear pixel index and the count of consecutive
    // enabled clocks: {tick, x, y, hsync, vsync, video_on, eol, eof}.
    function automatic logic [25:0] model_out(int pos, int run, logic en, logic rst,
                                              int hd, int hf, int hr, int hb,
                                              int vd, int vf, int vr, int vb,
                                              int dv, logic hp, logic vp);
        int   ht, vt, x, y;
        logic tk, hs, vs, von, el, ef;
        ht  = hd + hf + hr + hb;
        vt  = vd + vf + vr + vb;
        x   = pos % ht;
        y   = pos / ht;
        tk  = en && !rst && ((run % dv) == dv - 1);
        hs  = (x >= hd + hf && x < hd + hf + hr) ? hp : !hp;
        vs  = (y >= vd + vf && y < vd + vf + vr) ? vp : !vp;
        von = (x < hd) && (y < vd);
        el  = tk && (x == ht - 1);
        ef  = el && (y == vt - 1);
        return {tk, 10'(x), 10'(y), hs, vs, von, el, ef};
    endfunction

    int run_a = 0, pos_a = 0, run_b = 0, pos_b = 0, run_c = 0, pos_c = 0;

    // Model state A: 800x525 raster, two clocks per pixel.
    always @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            run_a <= 0; pos_a <= 0;
        end else begin
            if (en_a && (run_a % 2) == 1) pos_a <= (pos_a + 1) % (800 * 525);
            run_a <= en_a ? run_a + 1 : 0;
        end
    end

    // Model state B: 8x6 raster, one clock per pixel.
    always @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            run_b <= 0; pos_b <= 0;
        end else begin
            if (en_b) pos_b <= (pos_b + 1) % (8 * 6);
            run_b <= en_b ? run_b + 1 : 0;
        end
    end

    // Model state C: 800x15 raster, two clocks per pixel.
    always @(posedge clk or posedge rst_c) begin
        if (rst_c) begin
            run_c <= 0; pos_c <= 0;
        end else begin
            if (en_c && (run_c % 2) == 1) pos_c <= (pos_c + 1) % (800 * 15);
            run_c <= en_c ? run_c + 1 : 0;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    endtask

    task automatic check_vec(string name, logic [25:0] act, logic [25:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    endtask

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            check_vec("a_raster", {tick_a, x_a, y_a, hs_a, vs_a, von_a, eol_a, eof_a},
                model_out(pos_a, run_a, en_a, rst_a, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0));
            check_vec("b_raster", {tick_b, x_b, y_b, hs_b, vs_b, von_b, eol_b, eof_b},
                model_out(pos_b, run_b, en_b, rst_b, 4, 1, 2, 1, 3, 1, 1, 1, 1, 1'b1, 1'b1));
            check_vec("c_raster", {tick_c, x_c, y_c, hs_c, vs_c, von_c, eol_c, eof_c},
                model_out(pos_c, run_c, en_c, rst_c, 640, 16, 96, 48, 8, 2, 2, 3, 2, 1'b0, 1'b1));
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- driver A: default timing ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0;
        step(1);
        check("a_first_tick", 32'(tick_a), 1);
        check("a_x_edge1", 32'(x_a), 0);
        step(1);
        check("a_tick_edge2", 32'(tick_a), 0);
        check("a_x_edge2", 32'(x_a), 1);
        step(1597);
        check("a_eol_1599", 32'(eol_a), 1);
        check("a_x_1599", 32'(x_a), 799);
        step(1);
        check("a_x_wrap", 32'(x_a), 0);
        check("a_y_wrap", 32'(y_a), 1);
        check("a_eol_1600", 32'(eol_a), 0);
        step(1311);
        check("a_x_655", 32'(x_a), 655);
        check("a_hs_655", 32'(hs_a), 1);
        step(1);
        check("a_hs_656", 32'(hs_a), 0);
        check("a_von_656", 32'(von_a), 0);
        en_a = 1'b0;
        #1 check("a_tick_hold", 32'(tick_a), 0);
        step(10);
        check("a_x_frozen", 32'(x_a), 656);
        check("a_hs_frozen", 32'(hs_a), 0);
        en_a = 1'b1;
        step(1);
        check("a_resume_tick", 32'(tick_a), 1);
        check("a_resume_x", 32'(x_a), 656);
        step(1);
        check("a_resume_next", 32'(x_a), 657);
        step(86);
        check("a_x_700", 32'(x_a), 700);
        rst_a = 1'b1;
        #1;
        check("a_rst_x", 32'(x_a), 0);
        check("a_rst_y", 32'(y_a), 0);
        check("a_rst_hs", 32'(hs_a), 1);
        check("a_rst_vs", 32'(vs_a), 1);
        check("a_rst_von", 32'(von_a), 1);
        step(2);
        rst_a = 1'b0;
        step(1);
        check("a_restart_tick", 32'(tick_a), 1);
        step(3200);
        done_a = 1'b1;
    end

    // ---------------- driver B: tiny raster, CLK_DIV=1, active-high syncs ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b0;
        en_b = 1'b1;
        #1 check("b_tick_now", 32'(tick_b), 1);
        step(4);
        check("b_x4", 32'(x_b), 4);
        check("b_hs_x4", 32'(hs_b), 0);
        check("b_von_x4", 32'(von_b), 0);
        step(1);
        check("b_hs_x5", 32'(hs_b), 1);
        step(1);
        check("b_hs_x6", 32'(hs_b), 1);
        step(1);
        check("b_hs_x7", 32'(hs_b), 0);
        check("b_eol_x7", 32'(eol_b), 1);
        step(1);
        check("b_y1", 32'(y_b), 1);
        step(23);
        check("b_vs_y3", 32'(vs_b), 0);
        step(1);
        check("b_vs_y4", 32'(vs_b), 1);
        step(8);
        check("b_vs_y5", 32'(vs_b), 0);
        step(7);
        check("b_eof", 32'(eof_b), 1);
        check("b_eof_y", 32'(y_b), 5);
        step(1);
        check("b_frame_x", 32'(x_b), 0);
        check("b_frame_y", 32'(y_b), 0);
        check("b_eof_after", 32'(eof_b), 0);
        step(35);
        check("b_x3", 32'(x_b), 3);
        en_b = 1'b0;
        step(5);
        check("b_x_frozen", 32'(x_b), 3);
        check("b_vs_frozen", 32'(vs_b), 1);
        en_b = 1'b1;
        #1 check("b_resume_tick", 32'(tick_b), 1);
        step(1);
        check("b_resume_x", 32'(x_b), 4);
        en_b = 1'b0;
        rst_b = 1'b1;
        #1;
        check("b_rst_vs", 32'(vs_b), 0);
        check("b_rst_hs", 32'(hs_b), 0);
        check("b_rst_y", 32'(y_b), 0);
        step(2);
        rst_b = 1'b0;
        en_b = 1'b1;
        step(100);
        done_b = 1'b1;
    end

    // ---------------- driver C: short frame, mixed polarity ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 rst_c = 1'b0;
        step(19000);
        check("c_x700", 32'(x_c), 700);
        check("c_y11", 32'(y_c), 11);
        check("c_vs_y11", 32'(vs_c), 1);
        check("c_hs_x700", 32'(hs_c), 0);
        rst_c = 1'b1;
        #1;
        check("c_rst_x", 32'(x_c), 0);
        check("c_rst_y", 32'(y_c), 0);
        check("c_rst_hs", 32'(hs_c), 1);
        check("c_rst_vs", 32'(vs_c), 0);
        check("c_rst_von", 32'(von_c), 1);
        check("c_rst_tick", 32'(tick_c), 0);
        step(2);
        rst_c = 1'b0;
        step(15999);
        check("c_vs_y9", 32'(vs_c), 0);
        step(1);
        check("c_y10", 32'(y_c), 10);
        check("c_vs_y10", 32'(vs_c), 1);
        step(7999);
        check("c_eof", 32'(eof_c), 1);
        check("c_eof_x", 32'(x_c), 799);
        check("c_eof_y", 32'(y_c), 14);
        step(1);
        check("c_wrap_x", 32'(x_c), 0);
        check("c_wrap_y", 32'(y_c), 0);
        check("c_wrap_eof", 32'(eof_c), 0);
        step(10);
        done_c = 1'b1;
    end

    // ---------------- run control and report ----------------
    initial begin
        repeat (2) @(posedge clk);
        cmp_on = 1'b1;
        for (int i = 0; i < 60000 && !(done_a && done_b && done_c); i++) @(posedge clk);
        if (!(done_a && done_b && done_c)) begin
            checks++;
            $display("FAIL timeout: actual done=%b%b%b required 111", done_a, done_b, done_c);
        end
        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
